mul_div_control_unit: RTL and testbench
=======================================

// Module: mul_div_control_unit
// PURPOSE
//  Hard-wired control sequencer for the datapath's MUL/DIV instruction path: emits PCout/MARin/IncPC/... per step.
//  Fetches via T0-T2, then runs T3-T6 so Ra->Y, Ra op Rb->Z, Zlo->LO, Zhi->HI.
//  Replaces bench-driven control; sits between the IR/memory handshake and the datapath enables.
// PARAMETERS
//  OP_MUL       5'b01111  IR[31:27] code for mul
//  OP_DIV       5'b10000  IR[31:27] code for div
//  MEM_TIMEOUT  16        max cycles waiting in T1 for Mem_ready before fault
// PORTS
//  Clock      in   1   system clock, rising edge
//  Clear      in   1   asynchronous, active-low reset
//  Run_in     in   1   1 = keep executing; sampled only in IDLE and at end of T6
//  IR         in   32  instruction register; [31:27] op, [26:23] Ra, [22:19] Rb
//  Mem_ready  in   1   memory read data valid on Mdatain this cycle
//  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin  out 1 each  datapath enables
//  ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin             out 1 each  Z/HI/LO enables
//  Gra, Grb, Rout  out  1   select Ra/Rb field onto bus via register decoder
//  ALU_op     out  5   ALU operation; opcode in T4, 0 otherwise
//  Running    out  1   1 in any T-state
//  Fault      out  1   sticky; illegal opcode or memory timeout
// BEHAVIOUR
//  Moore FSM; all outputs decoded from state register only. Async Clear low -> IDLE, every output 0, counter 0.
//  States / outputs (1 cycle each unless noted):
//   IDLE : none. Run_in=1 -> T0; else stay.
//   T0   : PCout, MARin, IncPC, ZLowIn, ZHighIn -> T1.
//   T1   : Zlowout, PCin (first T1 cycle only), Read, MDRin (all T1 cycles). Mem_ready=1 -> T2;
//          else wait_cnt++; wait_cnt reaches MEM_TIMEOUT-1 with Mem_ready=0 -> FAULT.
//   T2   : MDRout, IRin -> T3.
//   T3   : IR[31:27] in {OP_MUL,OP_DIV}: Gra, Rout, Yin -> T4; else no enables -> FAULT.
//   T4   : Grb, Rout, ALU_op=IR[31:27], ZLowIn, ZHighIn -> T5.
//   T5   : Zlowout, LOin -> T6.
//   T6   : Zhighout, HIin -> T0 if Run_in=1, else IDLE.
//   FAULT: Fault=1, all enables 0; exits only via Clear.
//  PCin pulses exactly once per fetch even when T1 stretches (PC increments once).
//  wait_cnt: $clog2(MEM_TIMEOUT) bits, cleared on T1 entry; never wraps.
//  Latency: 7 cycles T0->T6 with Mem_ready=1 in first T1 cycle; +1 per wait cycle.
//  Run_in falling mid-instruction: instruction completes through T6, then IDLE.
//  IR changing after T2 while in T3-T6 is datapath error; FSM samples IR[31:27] in T3 and T4 only.
//  Clear mid-instruction: immediate IDLE; partial LO/HI writes are not rolled back.
//  Never two bus drivers: PCout, Zlowout, Zhighout, MDRout, Rout mutually exclusive in every state.
//  Running=1 in T0-T6; 0 in IDLE/FAULT.
// TESTING
//  Clear low 3 cycles then high, Run_in=0 -> stays IDLE, all outputs 0, Running=0.
//  Run_in=1, Mem_ready=1 always, IR=32'h7B380000 -> T0..T6 in 7 cycles; ALU_op=5'b01111 only in T4; LOin then HIin; back to T0.
//  IR=32'h83380000 (div) -> ALU_op=5'b10000 in T4, same sequence; R6=0x00000064,R7=0x7 in datapath -> LO=0xE, HI=0x2.
//  Mem_ready low 5 cycles in T1 -> Read/MDRin high 6 cycles, PCin high 1 cycle, then T2.
//  Mem_ready never high -> FAULT after 16 T1 cycles, Fault=1 stays until Clear; IR op 5'b00011 -> FAULT from T3.
//  Clear asserted in T4 -> outputs 0 same timestep; Run_in dropped in T3 -> T6 still completes, then IDLE.

Source files
------------

// File: rtl/mul_div_control_unit_if.sv
// Handshake and enable bundle between the MUL/DIV control sequencer and the datapath.
// The sequencer connects through the slave modport; the datapath or bench side uses master.
interface mul_div_control_unit_if;
    logic        Run_in;
    logic [31:0] IR;
    logic        Mem_ready;

    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        ZLowIn;
    logic        ZHighIn;
    logic        Zlowout;
    logic        Zhighout;
    logic        LOin;
    logic        HIin;
    logic        Gra;
    logic        Grb;
    logic        Rout;
    logic [4:0]  ALU_op;
    logic        Running;
    logic        Fault;

    modport slave (
        input  Run_in, IR, Mem_ready,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
               ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin,
               Gra, Grb, Rout, ALU_op, Running, Fault
    );

    modport master (
        output Run_in, IR, Mem_ready,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
               ZLowIn, ZHighIn, Zlowout, Zhighout, LOin, HIin,
               Gra, Grb, Rout, ALU_op, Running, Fault
    );
endinterface

// File: rtl/mul_div_control_unit.sv
// Hard-wired Moore sequencer for MUL/DIV: fetch in T0-T2, execute in T3-T6.
// It drives one bus source per step and latches a sticky fault on an illegal opcode or a memory timeout.
module mul_div_control_unit #(
    parameter logic [4:0] OP_MUL      = 5'b01111,
    parameter logic [4:0] OP_DIV      = 5'b10000,
    parameter int         MEM_TIMEOUT = 16
) (
    input logic                   Clock,
    input logic                   Clear,
    mul_div_control_unit_if.slave bus
);
    localparam int                 CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       opcode;
    logic             op_legal;

    assign opcode   = bus.IR[31:27];
    assign op_legal = (opcode == OP_MUL) || (opcode == OP_DIV);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= S_IDLE;
        else        state <= state_next;
    end

    // Held at zero outside T1, so the first T1 cycle always sees zero; saturates instead of wrapping.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)
            wait_cnt <= '0;
        else if (state != S_T1)
            wait_cnt <= '0;
        else if (!bus.Mem_ready && wait_cnt != CNT_LAST)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.Run_in) state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1: begin
                if (bus.Mem_ready)             state_next = S_T2;
                else if (wait_cnt == CNT_LAST) state_next = S_FAULT;
            end
            S_T2:    state_next = S_T3;
            S_T3:    state_next = op_legal ? S_T4 : S_FAULT;
            S_T4:    state_next = S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = bus.Run_in ? S_T0 : S_IDLE;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Rout     = 1'b0;
        bus.ALU_op   = 5'd0;
        bus.Running  = 1'b0;
        bus.Fault    = 1'b0;
        case (state)
            S_T0: begin
                bus.PCout   = 1'b1;
                bus.MARin   = 1'b1;
                bus.IncPC   = 1'b1;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = 1'b1;
                bus.Running = 1'b1;
            end
            S_T1: begin
                // PC is loaded only in the first T1 cycle so a stretched fetch still increments once.
                bus.Zlowout = 1'b1;
                bus.PCin    = (wait_cnt == '0);
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.Running = 1'b1;
            end
            S_T2: begin
                bus.MDRout  = 1'b1;
                bus.IRin    = 1'b1;
                bus.Running = 1'b1;
            end
            S_T3: begin
                bus.Gra     = op_legal;
                bus.Rout    = op_legal;
                bus.Yin     = op_legal;
                bus.Running = 1'b1;
            end
            S_T4: begin
                bus.Grb     = 1'b1;
                bus.Rout    = 1'b1;
                bus.ALU_op  = opcode;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = 1'b1;
                bus.Running = 1'b1;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.LOin    = 1'b1;
                bus.Running = 1'b1;
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.Running  = 1'b1;
            end
            S_FAULT: bus.Fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_div_control_unit.sv
// Scoreboard bench for mul_div_control_unit: an instruction-level script pushes the expected
// per-cycle enable vector, and a monitor compares it against the DUT on every falling edge.
module tb_mul_div_control_unit;
    logic Clock = 1'b0;
    logic Clear = 1'b1;

    mul_div_control_unit_if ifc();

    mul_div_control_unit dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (ifc.slave)
    );

    always #5 Clock = ~Clock;

    localparam logic [24:0] B_PCOUT    = 25'd1 << 24;
    localparam logic [24:0] B_MARIN    = 25'd1 << 23;
    localparam logic [24:0] B_INCPC    = 25'd1 << 22;
    localparam logic [24:0] B_PCIN     = 25'd1 << 21;
    localparam logic [24:0] B_READ     = 25'd1 << 20;
    localparam logic [24:0] B_MDRIN    = 25'd1 << 19;
    localparam logic [24:0] B_MDROUT   = 25'd1 << 18;
    localparam logic [24:0] B_IRIN     = 25'd1 << 17;
    localparam logic [24:0] B_YIN      = 25'd1 << 16;
    localparam logic [24:0] B_ZLOWIN   = 25'd1 << 15;
    localparam logic [24:0] B_ZHIGHIN  = 25'd1 << 14;
    localparam logic [24:0] B_ZLOWOUT  = 25'd1 << 13;
    localparam logic [24:0] B_ZHIGHOUT = 25'd1 << 12;
    localparam logic [24:0] B_LOIN     = 25'd1 << 11;
    localparam logic [24:0] B_HIIN     = 25'd1 << 10;
    localparam logic [24:0] B_GRA      = 25'd1 << 9;
    localparam logic [24:0] B_GRB      = 25'd1 << 8;
    localparam logic [24:0] B_ROUT     = 25'd1 << 7;
    localparam logic [24:0] B_RUN      = 25'd1 << 6;
    localparam logic [24:0] B_FAULT    = 25'd1 << 5;

    localparam logic [24:0] V_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN | B_ZHIGHIN | B_RUN;
    localparam logic [24:0] V_T1  = B_ZLOWOUT | B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] V_T2  = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [24:0] V_T3  = B_GRA | B_ROUT | B_YIN | B_RUN;
    localparam logic [24:0] V_T4  = B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN | B_RUN;
    localparam logic [24:0] V_T5  = B_ZLOWOUT | B_LOIN | B_RUN;
    localparam logic [24:0] V_T6  = B_ZHIGHOUT | B_HIIN | B_RUN;
    localparam logic [24:0] V_FLT = B_FAULT;

    logic [24:0] exp_q[$];
    string       nm_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [24:0] snap();
        return {ifc.PCout, ifc.MARin, ifc.IncPC, ifc.PCin, ifc.Read, ifc.MDRin, ifc.MDRout,
                ifc.IRin, ifc.Yin, ifc.ZLowIn, ifc.ZHighIn, ifc.Zlowout, ifc.Zhighout,
                ifc.LOin, ifc.HIin, ifc.Gra, ifc.Grb, ifc.Rout, ifc.Running, ifc.Fault,
                ifc.ALU_op};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive this cycle's inputs and record what the DUT should show in it.
    task automatic cyc(input logic clr, input logic rdy, input logic run,
                       input logic [24:0] e, input string nm);
        @(posedge Clock);
        #1;
        Clear         = clr;
        ifc.Mem_ready = rdy;
        ifc.Run_in    = run;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // st: 0 = completed through T6, 1 = ended in fault, 2 = aborted by Clear in T4.
    task automatic instr(input logic [31:0] ir, input int waits, input logic run_next,
                         input logic drop, input logic clr_t4, output int st);
        logic [4:0]  op;
        logic        legal;
        logic [24:0] act;
        op    = ir[31:27];
        legal = (op == 5'b01111) || (op == 5'b10000);
        st    = 0;
        cyc(1'b1, rb(), rb(), V_T0, "T0");
        ifc.IR = ir;
        for (int i = 0; i <= waits && i < 16; i++)
            cyc(1'b1, (i == waits), rb(), (i == 0) ? (V_T1 | B_PCIN) : V_T1, "T1");
        if (waits >= 16) begin
            st = 1;
            return;
        end
        cyc(1'b1, rb(), rb(), V_T2, "T2");
        cyc(1'b1, rb(), drop ? 1'b0 : rb(), legal ? V_T3 : B_RUN, "T3");
        if (!legal) begin
            st = 1;
            return;
        end
        cyc(1'b1, rb(), drop ? 1'b0 : rb(), V_T4 | {20'd0, op}, "T4");
        if (clr_t4) begin
            @(negedge Clock);
            #1;
            Clear = 1'b0;
            #1;
            act = snap();
            checks++;
            if (act !== 25'd0) begin
                errors++;
                $display("FAIL clear_async: got %h want 0000000", act);
            end
            cyc(1'b0, 1'b0, 1'b0, 25'd0, "clear_hold");
            st = 2;
            return;
        end
        cyc(1'b1, rb(), drop ? 1'b0 : rb(), V_T5, "T5");
        cyc(1'b1, rb(), run_next, V_T6, "T6");
    endtask

    // Brings the sequencer back to a cycle from which the next instruction starts in T0.
    task automatic settle(input int st, input logic run_next);
        if (st == 1) begin
            repeat (3) cyc(1'b1, rb(), rb(), V_FLT, "fault_hold");
            cyc(1'b0, 1'b0, 1'b0, 25'd0, "fault_clear");
            cyc(1'b1, 1'b0, 1'b1, 25'd0, "idle_go");
        end else if (st == 2) begin
            cyc(1'b1, 1'b0, 1'b1, 25'd0, "idle_go");
        end else if (!run_next) begin
            repeat ($urandom_range(1, 3)) cyc(1'b1, rb(), 1'b0, 25'd0, "idle");
            cyc(1'b1, rb(), 1'b1, 25'd0, "idle_go");
        end
    endtask

    initial begin : monitor
        logic [24:0] act;
        logic [24:0] e;
        string       nm;
        int          drivers;
        forever begin
            @(negedge Clock);
            act     = snap();
            drivers = int'(act[24]) + int'(act[18]) + int'(act[13]) + int'(act[12]) + int'(act[7]);
            checks++;
            if (drivers > 1) begin
                errors++;
                $display("FAIL bus_exclusive: drivers=%0d want at most 1 (vec %h)", drivers, act);
            end
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got %h want %h at %0t", nm, act, e, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          st;
        int          kind;
        int          waits;
        logic [4:0]  op;
        logic [31:0] r;
        logic        run_next;
        logic        clr4;
        ifc.Run_in    = 1'b0;
        ifc.Mem_ready = 1'b0;
        ifc.IR        = 32'd0;
        #2 Clear = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 25'd0, "reset");
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 25'd0, "idle_run0");
        cyc(1'b1, 1'b0, 1'b1, 25'd0, "idle_go");

        instr(32'h7B380000, 0,  1'b1, 1'b0, 1'b0, st); settle(st, 1'b1);
        instr(32'h83380000, 0,  1'b1, 1'b0, 1'b0, st); settle(st, 1'b1);
        instr(32'h7B380000, 5,  1'b1, 1'b0, 1'b0, st); settle(st, 1'b1);
        instr(32'h83380000, 0,  1'b0, 1'b1, 1'b0, st); settle(st, 1'b0);
        instr(32'h7B380000, 15, 1'b1, 1'b0, 1'b0, st); settle(st, 1'b1);
        instr(32'h7B380000, 16, 1'b1, 1'b0, 1'b0, st); settle(st, 1'b1);
        instr(32'h1B380000, 0,  1'b1, 1'b0, 1'b0, st); settle(st, 1'b1);
        instr(32'h83380000, 1,  1'b1, 1'b0, 1'b1, st); settle(st, 1'b1);

        for (int n = 0; n < 60; n++) begin
            kind  = $urandom_range(0, 19);
            waits = (kind == 16) ? 16 : (kind == 17) ? 15 : $urandom_range(0, 7);
            op    = rb() ? 5'b01111 : 5'b10000;
            if (kind == 18) begin
                op = 5'($urandom_range(0, 31));
                if (op == 5'b01111 || op == 5'b10000) op = 5'b00000;
            end
            clr4     = (kind == 19);
            run_next = (n == 59) ? 1'b0 : rb();
            r        = $urandom;
            instr({op, r[26:0]}, waits, run_next, rb(), clr4, st);
            settle(st, run_next);
        end

        // The last settle ends on a cycle that launches T0, so finish one instruction and drop Run_in.
        instr(32'h7B380000, 2, 1'b0, 1'b0, 1'b0, st);
        repeat (3) cyc(1'b1, rb(), 1'b0, 25'd0, "idle_end");
        @(negedge Clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
